// File: rtl/fetch_queue.sv
// Fetch queue: sequential instruction fetcher feeding a small in-order FIFO
// that hands {instruction, pc} pairs to decode with a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at a word-aligned target.
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.

module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic [31:0]              imem_address,
    input  logic [31:0]              imem_data,
    input  logic                     fetch_enable,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_data,
    output logic [31:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      fetchPcQ, fetchPcD;
    logic [PTR_W-1:0] headQ, headD;
    logic [PTR_W-1:0] tailQ, tailD;
    logic [CNT_W-1:0] countQ, countD;

    // Storage is never reset; every read is masked by the occupancy count.
    logic [31:0] dataMem [DEPTH];
    logic [31:0] pcMem   [DEPTH];

    logic qValid;
    logic qFull;
    logic push;
    logic pop;

    // Handshake qualifiers; a redirect suppresses both push and pop.
    always_comb begin
        qValid = (countQ != '0);
        qFull  = (countQ == FULL_COUNT);
        push   = fetch_enable & ~redirect_valid & ~qFull;
        pop    = qValid & inst_ready & ~redirect_valid;
    end

    // Next-state for fetch pc, pointers and occupancy; redirect wins over everything.
    always_comb begin
        fetchPcD = fetchPcQ;
        headD    = headQ;
        tailD    = tailQ;
        countD   = countQ;
        if (redirect_valid) begin
            fetchPcD = {redirect_pc[31:2], 2'b00};
            headD    = '0;
            tailD    = '0;
            countD   = '0;
        end else begin
            if (push) begin
                tailD    = tailQ + PTR_W'(1);
                fetchPcD = fetchPcQ + 32'd4;
            end
            if (pop) begin
                headD = headQ + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   countD = countQ + CNT_W'(1);
                2'b01:   countD = countQ - CNT_W'(1);
                default: countD = countQ;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetchPcQ <= RESET_PC;
            headQ    <= '0;
            tailQ    <= '0;
            countQ   <= '0;
        end else begin
            fetchPcQ <= fetchPcD;
            headQ    <= headD;
            tailQ    <= tailD;
            countQ   <= countD;
        end
    end

    // Capture the fetched word and its address at the tail on each push.
    always_ff @(posedge clock) begin
        if (push) begin
            dataMem[tailQ] <= imem_data;
            pcMem[tailQ]   <= fetchPcQ;
        end
    end

    assign imem_address = fetchPcQ;
    assign inst_valid   = qValid;
    assign inst_data    = qValid ? dataMem[headQ] : 32'd0;
    assign inst_pc      = qValid ? pcMem[headQ]   : 32'd0;
    assign count        = countQ;

endmodule
